mimasuo_ctrl: RTL

Session controller for the two-button combination lock. It turns button0/button1 presses into code bits and manages the entry session, including inter-press timeout and abort. It compares each entry against a stored, reprogrammable code, holds UNLOCK for a fixed window, counts failures and enforces a lockout. It sits between the debounced button inputs and the door actuator/alarm.

---
 rtl/mimasuo_pkg.sv | 19 +
 rtl/mimasuo_press_detect.sv | 39 +++
 rtl/mimasuo_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mimasuo_pkg.sv
// Shared definitions for the two-button combination lock controller.
// State encodings are visible on state_o for debug.
package mimasuo_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_PROG    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_e;

    localparam logic BTN0_BIT = 1'b0;
    localparam logic BTN1_BIT = 1'b1;

endpackage

// File: rtl/mimasuo_press_detect.sv
// Turns the two level-sensitive buttons into press strobes.
// Previous-button registers reset high so a held button is not a press.
module mimasuo_press_detect
    import mimasuo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic button0_i,
    input  logic button1_i,
    output logic press_valid_o,
    output logic press_bit_o,
    output logic press_abort_o
);

    logic prev0_q;
    logic prev1_q;
    logic rise0;
    logic rise1;

    // Remember the button levels seen at the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev0_q <= 1'b1;
            prev1_q <= 1'b1;
        end else begin
            prev0_q <= button0_i;
            prev1_q <= button1_i;
        end
    end

    assign rise0 = button0_i & ~prev0_q;
    assign rise1 = button1_i & ~prev1_q;

    // Abort covers a double rise as well as a rise with the other held.
    assign press_abort_o = (rise0 & button1_i) | (rise1 & button0_i);
    assign press_valid_o = (rise0 | rise1) & ~press_abort_o;
    assign press_bit_o   = rise1 ? BTN1_BIT : BTN0_BIT;

endmodule

// File: rtl/mimasuo_ctrl.sv
// Session controller: collects code bits, checks them, opens the door,
// reprograms the code, and enforces a lockout after repeated failures.
module mimasuo_ctrl
    import mimasuo_pkg::*;
#(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b1010,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  UNLOCK_CYCLES  = 8,
    parameter int                  LOCKOUT_CYCLES = 32,
    parameter int                  TIMEOUT_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               button0,
    input  logic                               button1,
    input  logic                               prog_en,
    output logic                               UNLOCK,
    output logic                               alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt,
    output logic [STATE_W-1:0]                 state_o
);

    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int T_A    = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                            UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int T_MAX  = (T_A > TIMEOUT_CYCLES) ? T_A : TIMEOUT_CYCLES;
    localparam int TMR_W  = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CODE_LEN);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0]  TO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  UL_LAST  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LO_LAST  = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);
    localparam logic [FAIL_W-1:0] FAIL_ONE = FAIL_W'(1);

    state_e              state_q, state_d;
    logic [CODE_LEN-1:0] entry_q, entry_d;
    logic [CODE_LEN-1:0] code_q, code_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic                unlock_q;
    logic                alarm_q;

    logic                press_valid;
    logic                press_bit;
    logic                press_abort;
    logic [CODE_LEN:0]   entry_ext;
    logic [CODE_LEN-1:0] entry_sh;
    logic [CNT_W-1:0]    cnt_inc;
    logic [TMR_W-1:0]    tmr_inc;

    mimasuo_press_detect u_press (
        .clk           (clk),
        .rst           (rst),
        .button0_i     (button0),
        .button1_i     (button1),
        .press_valid_o (press_valid),
        .press_bit_o   (press_bit),
        .press_abort_o (press_abort)
    );

    // MSB-first shift: the newest bit always lands in the LSB.
    assign entry_ext = {entry_q, press_bit};
    assign entry_sh  = entry_ext[CODE_LEN-1:0];
    assign cnt_inc   = cnt_q + CNT_ONE;
    assign tmr_inc   = tmr_q + TMR_ONE;

    // Next-state, entry, counter and code update for the session FSM.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE: begin
                if (press_valid) begin
                    entry_d    = '0;
                    entry_d[0] = press_bit;
                    cnt_d      = CNT_ONE;
                    tmr_d      = '0;
                    state_d    = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
                end
            end
            S_ENTRY, S_PROG: begin
                if (press_abort) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else if (press_valid) begin
                    entry_d = entry_sh;
                    cnt_d   = cnt_inc;
                    tmr_d   = '0;
                    if (cnt_inc == CNT_LAST) begin
                        if (state_q == S_PROG) begin
                            code_d  = entry_sh;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end
                end else if (tmr_q == TO_LAST) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            S_CHECK: begin
                cnt_d = '0;
                tmr_d = '0;
                if (entry_q == code_q) begin
                    fail_d  = '0;
                    state_d = S_OPEN;
                end else begin
                    if (fail_q != FAIL_MAX) begin
                        fail_d = fail_q + FAIL_ONE;
                    end
                    state_d = (fail_d == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_OPEN: begin
                if (prog_en) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    state_d = S_PROG;
                end else if (tmr_q == UL_LAST) begin
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            S_LOCKOUT: begin
                if (tmr_q == LO_LAST) begin
                    tmr_d   = '0;
                    fail_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            default: begin
                entry_d = '0;
                cnt_d   = '0;
                tmr_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            entry_q  <= '0;
            code_q   <= DEFAULT_CODE;
            cnt_q    <= '0;
            tmr_q    <= '0;
            fail_q   <= '0;
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            fail_q   <= fail_d;
            unlock_q <= (state_d == S_OPEN) || (state_d == S_PROG);
            alarm_q  <= (state_d == S_LOCKOUT);
        end
    end

    assign UNLOCK   = unlock_q;
    assign alarm    = alarm_q;
    assign fail_cnt = fail_q;
    assign state_o  = state_q;

endmodule
